// File: rtl/sim_run_controller.sv
// Run controller for processor simulation/bring-up: core reset sequencing, cycle and
// retire counting, and pass/timeout/hang detection. Hang detection is built only with RUNCTL_STALL_DET_EN.
module sim_run_controller #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned STALL_LIMIT    = 64,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  input  logic             retire_i,
  input  logic             restart_i,
  output logic             core_rst_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Timeout compare is done at least 32 bits wide so a narrow counter never aliases the limit
  localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;

  typedef enum logic [2:0] {
    RESET_HOLD,
    RUN,
    DONE_PASS,
    DONE_TIMEOUT,
    DONE_HANG
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_d, instr_d;
  logic [CNT_W-1:0]  cycle_inc, instr_inc;
  logic              timeout_hit;
  logic [1:0]        status_d;

`ifdef RUNCTL_STALL_DET_EN
  localparam int unsigned IDLE_W = $clog2(STALL_LIMIT);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              hang_hit;

  assign hang_hit = (idle_q == IDLE_W'(STALL_LIMIT - 1)) && !retire_i;
`else
  localparam int unsigned unused_stall_limit = STALL_LIMIT;
`endif

  // Saturating increments
  assign cycle_inc   = (&cycle_cnt_o) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);
  assign instr_inc   = (&instr_cnt_o) ? instr_cnt_o : instr_cnt_o + CNT_W'(1);
  assign timeout_hit = CMP_W'(cycle_cnt_o) == CMP_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_HOLD;
      hold_q      <= '0;
      cycle_cnt_o <= '0;
      instr_cnt_o <= '0;
      core_rst_o  <= 1'b1;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      status_o    <= 2'b00;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_cnt_o <= cycle_d;
      instr_cnt_o <= instr_d;
      core_rst_o  <= (state_d == RESET_HOLD);
      running_o   <= (state_d == RUN);
      done_o      <= (state_d == DONE_PASS) || (state_d == DONE_TIMEOUT) || (state_d == DONE_HANG);
      status_o    <= status_d;
    end
  end

`ifdef RUNCTL_STALL_DET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cycle_d = cycle_cnt_o;
    instr_d = instr_cnt_o;
`ifdef RUNCTL_STALL_DET_EN
    idle_d  = idle_q;
`endif
    if (restart_i) begin
      state_d = RESET_HOLD;
      hold_d  = '0;
      cycle_d = '0;
      instr_d = '0;
`ifdef RUNCTL_STALL_DET_EN
      idle_d  = '0;
`endif
    end else begin
      unique case (state_q)
        RESET_HOLD: begin
          if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
            state_d = RUN;
            hold_d  = '0;
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
          end
        end
        RUN: begin
          cycle_d = cycle_inc;
          if (retire_i) instr_d = instr_inc;
`ifdef RUNCTL_STALL_DET_EN
          idle_d = retire_i ? '0 : idle_q + IDLE_W'(1);
`endif
          if (halt_i)           state_d = DONE_PASS;
          else if (timeout_hit) state_d = DONE_TIMEOUT;
`ifdef RUNCTL_STALL_DET_EN
          else if (hang_hit)    state_d = DONE_HANG;
`endif
        end
        DONE_PASS, DONE_TIMEOUT, DONE_HANG: ;
        default: state_d = RESET_HOLD;
      endcase
    end
  end

  // Status follows the state being entered so it is registered alongside it
  always_comb begin
    status_d = 2'b00;
    case (state_d)
      DONE_PASS:    status_d = 2'b01;
      DONE_TIMEOUT: status_d = 2'b10;
      DONE_HANG:    status_d = 2'b11;
      default:      status_d = 2'b00;
    endcase
  end

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Parametrised run controller for processor simulation and bring-up.
- Generates the core reset sequence and counts cycles and retired instructions.
- Detects program completion, timeout and pipeline hang, and latches a final status.
- Sits between the top-level clk/rst and the processor's rst input; drives a bench or on-board status logic.

Parameters:
RST_CYCLES, 4, number of cycles core_rst_o stays high after rst deasserts (>=1)
TIMEOUT_CYCLES, 1000, RUN cycles allowed before declaring timeout (>=2)
STALL_LIMIT, 64, consecutive non-retiring RUN cycles before declaring hang (>=2)
CNT_W, 32, width of cycle and instruction counters

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
halt_i  input  1  processor signals program end (halt/terminal instruction retired)
retire_i  input  1  one instruction retired this cycle
restart_i  input  1  synchronous pulse: abort or rerun, re-enter reset sequence
core_rst_o  output  1  reset to processor, registered
running_o  output  1  high in RUN
done_o  output  1  high in any DONE state
status_o  output  2  00 reset/run, 01 pass, 10 timeout, 11 hang
cycle_cnt_o  output  CNT_W  RUN cycles elapsed
instr_cnt_o  output  CNT_W  instructions retired in RUN

Behaviour:
- Reset is one clock, asynchronous, active-high.
- While rst is high:
  - state RESET_HOLD, hold counter 0.
  - core_rst_o=1; running_o=0, done_o=0, status_o=00.
  - cycle_cnt_o=0, instr_cnt_o=0; internal idle counter 0.
- States: RESET_HOLD, RUN, DONE_PASS, DONE_TIMEOUT, DONE_HANG (one-hot or binary, implementer's choice).
- RESET_HOLD:
  - Hold counter increments each clk.
  - When hold==RST_CYCLES-1, next state is RUN and core_rst_o drops on that same edge.
  - core_rst_o is therefore high for exactly RST_CYCLES rising edges after rst falls.
  - halt_i and retire_i are ignored.
- RUN:
  - cycle_cnt_o +1 every cycle.
  - instr_cnt_o +1 when retire_i=1.
  - Both counters saturate at all-ones and never wrap.
  - Idle counter clears on retire_i=1, otherwise +1.
- RUN exits, evaluated on the current cycle's inputs, priority highest first:
  1. restart_i=1 -> RESET_HOLD.
  2. halt_i=1 -> DONE_PASS.
  3. cycle_cnt_o==TIMEOUT_CYCLES-1 -> DONE_TIMEOUT.
  4. idle==STALL_LIMIT-1 and retire_i=0 -> DONE_HANG.
- Exit-cycle counting:
  - A retire_i coincident with halt_i is counted.
  - The exit cycle itself increments cycle_cnt_o, so a timeout freezes at cycle_cnt_o==TIMEOUT_CYCLES.
- DONE_*:
  - done_o=1; status_o latched per state.
  - Counters frozen; core_rst_o stays 0 so core state remains inspectable.
  - halt_i and retire_i are ignored.
  - Only restart_i or rst leave a DONE state.
- restart_i in any state:
  - Next state RESET_HOLD; hold, idle, cycle and instr counters cleared.
  - core_rst_o=1 from the next edge.
  - done_o and status_o clear on that edge.
- rst mid-operation: immediate asynchronous return to the reset values above, regardless of state.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro RUNCTL_STALL_DET_EN.
- Defined: idle counter and DONE_HANG are implemented as described.
- Undefined:
  - No idle counter; DONE_HANG is unreachable.
  - status_o never shows 11; STALL_LIMIT is unused.
  - Only halt and timeout end a run.

Test Plan:
- Reset sequence, defaults (RST_CYCLES=4): rst high 2 cycles then low -> core_rst_o high for exactly 4 edges after rst falls, then running_o=1, status_o=00, counters 0.
- Normal pass: retire_i every cycle, halt_i with retire_i on RUN cycle 20 -> DONE_PASS, status_o=01, cycle_cnt_o=20, instr_cnt_o=20, both frozen for 50 further cycles.
- Timeout (TIMEOUT_CYCLES=30, STALL_LIMIT=64): retire_i every other cycle, no halt -> DONE_TIMEOUT, status_o=10, cycle_cnt_o=30; halt_i and timeout on the same cycle -> status_o=01.
- Hang (macro defined, STALL_LIMIT=8): 5 retires then retire_i=0 -> DONE_HANG after 8 idle cycles, status_o=11, instr_cnt_o=5. Same stimulus with macro undefined -> run continues to timeout, status_o=10.
- Restart, first case: restart_i during RUN at cycle 10 -> counters clear, core_rst_o high 4 cycles, new run starts.
- Restart, second case: restart_i coincident with halt_i -> RESET_HOLD, not DONE_PASS.
- Async reset: assert rst mid-cycle while in DONE_PASS -> outputs return to reset values before the next clk edge; saturation check with CNT_W=4 -> cycle_cnt_o holds at 15.
